// File: rtl/mlp2_seq_engine.sv
// Time-multiplexed two-layer fixed-point MLP: one MAC walks hidden then output neurons,
// with on-chip weight registers, streamed input/output handshakes and saturating results.
module mlp2_seq_engine #(
    parameter int IN_SIZE  = 4,
    parameter int HIDDEN1  = 3,
    parameter int OUT_SIZE = 2,
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter int ACC_W    = 40,
    localparam int W1N     = HIDDEN1 * IN_SIZE,
    localparam int W2N     = OUT_SIZE * HIDDEN1,
    localparam int WMAX    = (W1N > W2N) ? W1N : W2N,
    localparam int AW      = (WMAX > 1) ? $clog2(WMAX) : 1,
    localparam int OW      = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w_we,
    input  logic             w_sel,
    input  logic [AW-1:0]    w_addr,
    input  logic [WIDTH-1:0] w_data,
    input  logic             relu_hidden,
    input  logic             relu_out,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OW-1:0]    out_idx,
    output logic             out_last,
    output logic             sat,
    output logic             busy
);

    localparam int XA   = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int HA   = (HIDDEN1 > 1) ? $clog2(HIDDEN1) : 1;
    localparam int KMAX = (IN_SIZE > HIDDEN1) ? IN_SIZE : HIDDEN1;
    localparam int KW   = $clog2(KMAX + 1);
    localparam int NMAX = (HIDDEN1 > OUT_SIZE) ? HIDDEN1 : OUT_SIZE;
    localparam int NW   = (NMAX > 1) ? $clog2(NMAX) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_L1   = 3'd2,
        S_L2   = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t state_r, next_s;

    logic signed [WIDTH-1:0] w1_mem_r [0:2**AW-1];
    logic signed [WIDTH-1:0] w2_mem_r [0:2**AW-1];
    logic signed [WIDTH-1:0] x_buf_r  [0:2**XA-1];
    logic signed [WIDTH-1:0] h_buf_r  [0:2**HA-1];
    logic signed [WIDTH-1:0] o_buf_r  [0:2**OW-1];

    logic signed [ACC_W-1:0]   acc_r;
    logic [KW-1:0]             k_cnt_r;
    logic [NW-1:0]             n_cnt_r;
    logic [AW-1:0]             w_ptr_r;
    logic                      relu_h_r, relu_o_r;
    logic                      in_ready_r, busy_r, out_valid_r, out_last_r, sat_r;
    logic [WIDTH-1:0]          out_data_r;
    logic [OW-1:0]             out_idx_r;

    logic                      in_ready_s, busy_s;
    logic                      in_fire_s, out_fire_s, load_last_s, fin_s, last_s, wr_ok_s;
    logic signed [WIDTH-1:0]   mul_a_s, mul_b_s, res_s, final_s;
    logic signed [2*WIDTH-1:0] prod_s;
    logic signed [ACC_W-1:0]   prod_ext_s, shifted_s;
    logic                      sat_now_s, relu_s;
    logic [OW-1:0]             nidx_s;

    assign in_fire_s   = in_valid & in_ready_r;
    assign out_fire_s  = out_valid_r & out_ready;
    assign load_last_s = (k_cnt_r == KW'(IN_SIZE - 1));
    assign nidx_s      = out_idx_r + OW'(1);
    assign wr_ok_s     = w_we && (state_r == S_IDLE) &&
                         (w_sel ? (int'(w_addr) < W2N) : (int'(w_addr) < W1N));

    // State register plus the registered handshake/status flags derived from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= next_s;
            in_ready_r <= in_ready_s;
            busy_r     <= busy_s;
        end
    end

    // Neuron-finish and last-neuron detection for the active layer.
    always_comb begin
        fin_s  = 1'b0;
        last_s = 1'b0;
        case (state_r)
            S_L1: begin
                fin_s  = (k_cnt_r == KW'(IN_SIZE));
                last_s = (n_cnt_r == NW'(HIDDEN1 - 1));
            end
            S_L2: begin
                fin_s  = (k_cnt_r == KW'(HIDDEN1));
                last_s = (n_cnt_r == NW'(OUT_SIZE - 1));
            end
            default: begin
                fin_s  = 1'b0;
                last_s = 1'b0;
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_IDLE:  if (in_fire_s) next_s = (IN_SIZE == 1) ? S_L1 : S_LOAD; else next_s = S_IDLE;
            S_LOAD:  if (in_fire_s && load_last_s) next_s = S_L1; else next_s = S_LOAD;
            S_L1:    if (fin_s && last_s) next_s = S_L2; else next_s = S_L1;
            S_L2:    if (fin_s && last_s) next_s = S_OUT; else next_s = S_L2;
            S_OUT:   if (out_fire_s && out_last_r) next_s = S_IDLE; else next_s = S_OUT;
            default: next_s = S_IDLE;
        endcase
    end

    // Output decode, taken from the next state so the flags are registered with it.
    always_comb begin
        in_ready_s = (next_s == S_IDLE) || (next_s == S_LOAD);
        busy_s     = (next_s != S_IDLE);
    end

    // MAC operand select: L2 reuses the same multiplier on the hidden buffer and W2.
    always_comb begin
        mul_a_s = '0;
        mul_b_s = '0;
        if (state_r == S_L2) begin
            mul_a_s = h_buf_r[k_cnt_r[HA-1:0]];
            mul_b_s = w2_mem_r[w_ptr_r];
        end else begin
            mul_a_s = x_buf_r[k_cnt_r[XA-1:0]];
            mul_b_s = w1_mem_r[w_ptr_r];
        end
        prod_s     = mul_a_s * mul_b_s;
        prod_ext_s = ACC_W'(prod_s);
    end

    // Neuron result: floor rescale, clamp to the data range, then optional ReLU.
    always_comb begin
        shifted_s = acc_r >>> FRAC;
        sat_now_s = 1'b0;
        res_s     = '0;
        if (shifted_s > SAT_MAX) begin
            res_s     = SAT_MAX[WIDTH-1:0];
            sat_now_s = 1'b1;
        end else if (shifted_s < SAT_MIN) begin
            res_s     = SAT_MIN[WIDTH-1:0];
            sat_now_s = 1'b1;
        end else begin
            res_s     = shifted_s[WIDTH-1:0];
        end
        relu_s = (state_r == S_L2) ? relu_o_r : relu_h_r;
        if (relu_s && res_s[WIDTH-1]) begin
            final_s = '0;
        end else begin
            final_s = res_s;
        end
    end

    // Datapath: weight store, input capture, MAC/finish sequencing and output presentation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**AW; i++) begin
                w1_mem_r[i] <= '0;
                w2_mem_r[i] <= '0;
            end
            for (int i = 0; i < 2**XA; i++) x_buf_r[i] <= '0;
            for (int i = 0; i < 2**HA; i++) h_buf_r[i] <= '0;
            for (int i = 0; i < 2**OW; i++) o_buf_r[i] <= '0;
            acc_r       <= '0;
            k_cnt_r     <= '0;
            n_cnt_r     <= '0;
            w_ptr_r     <= '0;
            relu_h_r    <= 1'b0;
            relu_o_r    <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_idx_r   <= '0;
            out_last_r  <= 1'b0;
            sat_r       <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                if (w_sel) w2_mem_r[w_addr] <= w_data;
                else       w1_mem_r[w_addr] <= w_data;
            end
            case (state_r)
                S_IDLE: if (in_fire_s) begin
                    x_buf_r[0] <= in_data;
                    relu_h_r   <= relu_hidden;
                    relu_o_r   <= relu_out;
                    acc_r      <= '0;
                    n_cnt_r    <= '0;
                    w_ptr_r    <= '0;
                    sat_r      <= 1'b0;
                    k_cnt_r    <= (IN_SIZE == 1) ? KW'(0) : KW'(1);
                end
                S_LOAD: if (in_fire_s) begin
                    x_buf_r[k_cnt_r[XA-1:0]] <= in_data;
                    k_cnt_r <= load_last_s ? KW'(0) : k_cnt_r + KW'(1);
                end
                S_L1, S_L2: if (!fin_s) begin
                    acc_r   <= acc_r + prod_ext_s;
                    k_cnt_r <= k_cnt_r + KW'(1);
                    w_ptr_r <= w_ptr_r + AW'(1);
                end else begin
                    acc_r   <= '0;
                    k_cnt_r <= '0;
                    sat_r   <= sat_r | sat_now_s;
                    if (state_r == S_L1) begin
                        h_buf_r[n_cnt_r[HA-1:0]] <= final_s;
                    end else begin
                        o_buf_r[n_cnt_r[OW-1:0]] <= final_s;
                        if (n_cnt_r == NW'(0)) out_data_r <= final_s;
                    end
                    if (last_s) begin
                        n_cnt_r <= '0;
                        w_ptr_r <= '0;
                        if (state_r == S_L2) begin
                            out_valid_r <= 1'b1;
                            out_idx_r   <= '0;
                            out_last_r  <= (OUT_SIZE == 1);
                        end
                    end else begin
                        n_cnt_r <= n_cnt_r + NW'(1);
                    end
                end
                S_OUT: if (out_fire_s) begin
                    if (out_last_r) begin
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        out_idx_r   <= '0;
                        sat_r       <= 1'b0;
                    end else begin
                        out_idx_r  <= nidx_s;
                        out_data_r <= o_buf_r[nidx_s];
                        out_last_r <= (nidx_s == OW'(OUT_SIZE - 1));
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_idx   = out_idx_r;
    assign out_last  = out_last_r;
    assign sat       = sat_r;

endmodule

// File: doc/mlp2_seq_engine.md
Name: mlp2_seq_engine

Overview:
Sequential, parametrised successor to the combinational 2-layer fixed-point MLP (input -> hidden -> output). A single time-multiplexed MAC evaluates both layers. It has on-chip weight registers loaded through a write port, streamed input and output with valid/ready handshakes, saturating arithmetic and per-layer selectable ReLU. It sits between the feature stream source and the classifier result consumer.

Parameters:
IN_SIZE, 4, input vector length (>=1)
HIDDEN1, 3, hidden neuron count (>=1)
OUT_SIZE, 2, output neuron count (>=1)
WIDTH, 16, signed data/weight width, two's complement
FRAC, 8, fractional bits (Q(WIDTH-FRAC).FRAC), 0 < FRAC < WIDTH
ACC_W, 40, accumulator width; must be >= 2*WIDTH + clog2(max(IN_SIZE,HIDDEN1))

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
w_we  in  1  weight write strobe
w_sel  in  1  0 = W1 (HIDDEN1 x IN_SIZE), 1 = W2 (OUT_SIZE x HIDDEN1)
w_addr  in  AW=clog2(max(HIDDEN1*IN_SIZE, OUT_SIZE*HIDDEN1))  row-major index, row*cols+col
w_data  in  WIDTH  signed weight
relu_hidden  in  1  apply ReLU to hidden layer
relu_out  in  1  apply ReLU to output layer
in_valid  in  1  input element valid
in_ready  out  1  engine accepts input element
in_data  in  WIDTH  input element, index order 0..IN_SIZE-1
out_valid  out  1  output element valid
out_ready  in  1  consumer accepts output
out_data  out  WIDTH  output element
out_idx  out  clog2(OUT_SIZE) (min 1)  output element index
out_last  out  1  high with out_idx == OUT_SIZE-1
sat  out  1  some hidden or output result of this inference saturated; valid with out_valid
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst_n low at a clk edge): FSM -> IDLE. All weights, input/hidden buffers, accumulator and counters cleared to 0. in_ready=0, out_valid=0, out_data=0, out_idx=0, out_last=0, sat=0, busy=0. Mid-inference reset aborts with no output.
- States: IDLE -> LOAD -> L1 -> L2 -> OUT -> IDLE.
- IDLE: in_ready=1. A w_we write updates the selected weight at the next edge. Out-of-range w_addr is ignored. The first in_valid&in_ready stores element 0 and samples relu_hidden/relu_out for the whole inference. Element 0 is then the start of LOAD. If w_we and the first input handshake occur in the same cycle, both take effect.
- LOAD: in_ready=1. Each handshake stores the next element. On acceptance of element IN_SIZE-1 -> L1. With IN_SIZE=1, IDLE goes directly to L1. Weight writes are ignored in every state except IDLE.
- MAC: product = full 2*WIDTH signed product, sign-extended into ACC_W, one product per cycle.
- Neuron finish (1 cycle after the last MAC of a neuron): result = acc >>> FRAC (arithmetic, floor). Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. If saturation occurred, set sticky sat. Apply ReLU if enabled (negative -> 0). Store the result, clear acc.
- L1: HIDDEN1*(IN_SIZE+1) cycles. L2: OUT_SIZE*(HIDDEN1+1) cycles. Then -> OUT.
- Latency: out_valid rises exactly HIDDEN1*(IN_SIZE+1)+OUT_SIZE*(HIDDEN1+1) cycles after the edge accepting the last input element. With defaults this is 23.
- OUT: elements are presented in order 0..OUT_SIZE-1. out_data/out_idx/out_last/sat are held stable while out_valid & !out_ready. After the handshake with out_last -> IDLE: out_valid=0, sat cleared, in_ready=1 on the next cycle.
- in_ready=0 in L1/L2/OUT. Inputs presented then are not consumed.

Test Plan:
- Default params, W1 rows {-12,-47,11,65},{20,-18,21,3},{15,56,-4,23}, W2 rows {-5,-6,-17},{18,38,19}, relu_hidden=1, relu_out=0, input {256,512,768,1024} -> hidden {187,59,207}; out[0]=-19 (0xFFED), out[1]=37. sat=0. out_valid rises 23 cycles after the last input accept.
- Same stimulus with relu_out=1 -> out[0]=0, out[1]=37.
- All W1 and W2 = 0x7FFF, input all 0x7FFF -> hidden saturates to 32767, outputs 32767, sat=1. With W1 all 0x8000 and relu_hidden=0 -> hidden -32768, sat=1.
- out_ready held low 5 cycles in OUT -> out_data/out_idx stable and out_valid high throughout. in_valid during L1/L2/OUT is not accepted (in_ready=0). Weight writes while busy leave weights unchanged; the next inference gives the same result.
- rst_n low for 1 cycle during L2 -> all outputs 0 and busy=0 the following cycle. Weights read back 0: an inference with input {256,...} yields out {0,0}.
- Two back-to-back inferences, the second input offered the cycle after out_last handshake -> accepted immediately. The second result is independent of the first (sat not carried over).
